// File: rtl/hashmap_pkg.sv
// Shared encodings and sizing helper for the set-associative hashmap.
package hashmap_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_DELETE = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_NOP    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    RSP_NEW     = 2'd0,
    RSP_UPDATED = 2'd1,
    RSP_EVICTED = 2'd2,
    RSP_FAIL    = 2'd3
  } rsp_e;

  // Index width that stays at least one bit wide for single-entry dimensions.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hashmap_set.sv
// One set of WAYS key/value entries with valid bits and a round-robin victim pointer.
module hashmap_set
  import hashmap_pkg::*;
#(
  parameter int KEY_WIDTH   = 8,
  parameter int VALUE_WIDTH = 8,
  parameter int WAYS        = 2,
  parameter int WAY_W       = idx_w(WAYS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [KEY_WIDTH-1:0]   i_cmd_key,
  input  logic [KEY_WIDTH-1:0]   i_rd_key,
  output logic                   o_cmd_hit,
  output logic [WAY_W-1:0]       o_cmd_hit_way,
  output logic [WAY_W-1:0]       o_free_way,
  output logic                   o_full,
  output logic [WAY_W-1:0]       o_victim,
  output logic                   o_rd_hit,
  output logic [VALUE_WIDTH-1:0] o_rd_value,
  input  logic                   i_wr_en,
  input  logic                   i_del_en,
  input  logic [WAY_W-1:0]       i_way,
  input  logic [VALUE_WIDTH-1:0] i_wr_value,
  input  logic                   i_evict,
  input  logic                   i_clear
);

  logic [WAYS-1:0]        r_valid;
  logic [WAY_W-1:0]       r_victim;
  logic [KEY_WIDTH-1:0]   r_key   [WAYS];
  logic [VALUE_WIDTH-1:0] r_value [WAYS];

  // Descending scan so the lowest-index free way wins.
  always_comb begin
    o_cmd_hit     = 1'b0;
    o_cmd_hit_way = '0;
    o_free_way    = '0;
    o_full        = 1'b1;
    o_rd_hit      = 1'b0;
    o_rd_value    = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_key[i] == i_cmd_key)) begin
        o_cmd_hit     = 1'b1;
        o_cmd_hit_way = WAY_W'(i);
      end
      if (!r_valid[i]) begin
        o_free_way = WAY_W'(i);
        o_full     = 1'b0;
      end
      if (r_valid[i] && (r_key[i] == i_rd_key)) begin
        o_rd_hit   = 1'b1;
        o_rd_value = r_value[i];
      end
    end
  end

  assign o_victim = r_victim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_victim <= '0;
    end else if (i_clear) begin
      r_valid  <= '0;
      r_victim <= '0;
    end else begin
      if (i_wr_en)  r_valid[i_way] <= 1'b1;
      if (i_del_en) r_valid[i_way] <= 1'b0;
      if (i_evict) begin
        r_victim <= (r_victim == WAY_W'(WAYS - 1)) ? '0 : r_victim + WAY_W'(1);
      end
    end
  end

  // Payload storage is not reset; validity alone decides what is visible.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_key[i_way]   <= i_cmd_key;
      r_value[i_way] <= i_wr_value;
    end
  end

endmodule

// File: rtl/assoc_hashmap.sv
// Set-associative key/value cache: command port with registered status, independent registered lookup.
module assoc_hashmap
  import hashmap_pkg::*;
#(
  parameter int KEY_WIDTH   = 8,
  parameter int VALUE_WIDTH = 8,
  parameter int SETS        = 4,
  parameter int WAYS        = 2,
  parameter bit OVERWRITE   = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cmd_valid,
  input  logic [1:0]                          cmd_op,
  input  logic [KEY_WIDTH-1:0]                cmd_key,
  input  logic [VALUE_WIDTH-1:0]              cmd_value,
  output logic                                rsp_valid,
  output logic [1:0]                          rsp_code,
  input  logic                                read_request,
  input  logic [KEY_WIDTH-1:0]                read_key,
  output logic                                read_valid,
  output logic                                read_hit,
  output logic [VALUE_WIDTH-1:0]              read_value,
  output logic [$clog2(SETS*WAYS+1)-1:0]      count
);

  localparam int SET_W = idx_w(SETS);
  localparam int WAY_W = idx_w(WAYS);
  localparam int CNT_W = $clog2(SETS * WAYS + 1);
  localparam int MOD_W = (KEY_WIDTH > 32) ? KEY_WIDTH : 32;

  // cmd_valid and read_request carry no ready: every strobe is accepted on the edge that samples it.
  logic [SET_W-1:0] w_cmd_set, w_rd_set;
  assign w_cmd_set = SET_W'(MOD_W'(cmd_key) % MOD_W'(SETS));
  assign w_rd_set  = SET_W'(MOD_W'(read_key) % MOD_W'(SETS));

  logic                   w_set_hit      [SETS];
  logic [WAY_W-1:0]       w_set_hit_way  [SETS];
  logic [WAY_W-1:0]       w_set_free_way [SETS];
  logic                   w_set_full     [SETS];
  logic [WAY_W-1:0]       w_set_victim   [SETS];
  logic                   w_set_rd_hit   [SETS];
  logic [VALUE_WIDTH-1:0] w_set_rd_value [SETS];

  logic             w_wr_en, w_del_en, w_evict, w_clear, w_inc, w_dec, w_fire;
  logic [WAY_W-1:0] w_way;
  logic [1:0]       w_code;

  always_comb begin
    w_wr_en  = 1'b0;
    w_del_en = 1'b0;
    w_evict  = 1'b0;
    w_clear  = 1'b0;
    w_inc    = 1'b0;
    w_dec    = 1'b0;
    w_way    = '0;
    w_code   = RSP_NEW;
    if (cmd_valid) begin
      case (cmd_op)
        OP_WRITE: begin
          if (w_set_hit[w_cmd_set]) begin
            w_wr_en = 1'b1;
            w_way   = w_set_hit_way[w_cmd_set];
            w_code  = RSP_UPDATED;
          end else if (!w_set_full[w_cmd_set]) begin
            w_wr_en = 1'b1;
            w_way   = w_set_free_way[w_cmd_set];
            w_inc   = 1'b1;
            w_code  = RSP_NEW;
          end else if (OVERWRITE) begin
            w_wr_en = 1'b1;
            w_evict = 1'b1;
            w_way   = w_set_victim[w_cmd_set];
            w_code  = RSP_EVICTED;
          end else begin
            w_code  = RSP_FAIL;
          end
        end
        OP_DELETE: begin
          if (w_set_hit[w_cmd_set]) begin
            w_del_en = 1'b1;
            w_way    = w_set_hit_way[w_cmd_set];
            w_dec    = 1'b1;
            w_code   = RSP_NEW;
          end else begin
            w_code   = RSP_FAIL;
          end
        end
        OP_CLEAR: begin
          w_clear = 1'b1;
          w_code  = RSP_NEW;
        end
        default: ;
      endcase
    end
  end

  assign w_fire = cmd_valid && (cmd_op != OP_NOP);

  for (genvar s = 0; s < SETS; s++) begin : g_set
    logic w_sel;
    assign w_sel = (w_cmd_set == SET_W'(s));
    hashmap_set #(
      .KEY_WIDTH  (KEY_WIDTH),
      .VALUE_WIDTH(VALUE_WIDTH),
      .WAYS       (WAYS),
      .WAY_W      (WAY_W)
    ) u_set (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_cmd_key    (cmd_key),
      .i_rd_key     (read_key),
      .o_cmd_hit    (w_set_hit[s]),
      .o_cmd_hit_way(w_set_hit_way[s]),
      .o_free_way   (w_set_free_way[s]),
      .o_full       (w_set_full[s]),
      .o_victim     (w_set_victim[s]),
      .o_rd_hit     (w_set_rd_hit[s]),
      .o_rd_value   (w_set_rd_value[s]),
      .i_wr_en      (w_wr_en && w_sel),
      .i_del_en     (w_del_en && w_sel),
      .i_way        (w_way),
      .i_wr_value   (cmd_value),
      .i_evict      (w_evict && w_sel),
      .i_clear      (w_clear)
    );
  end

  logic                   r_rsp_valid, r_read_valid, r_read_hit;
  logic [1:0]             r_rsp_code;
  logic [VALUE_WIDTH-1:0] r_read_value;
  logic [CNT_W-1:0]       r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_code   <= '0;
      r_read_valid <= 1'b0;
      r_read_hit   <= 1'b0;
      r_read_value <= '0;
      r_count      <= '0;
    end else begin
      r_rsp_valid  <= w_fire;
      r_read_valid <= read_request;
      if (w_fire) r_rsp_code <= w_code;
      // Lookup sees pre-command state because sets update on this same edge.
      if (read_request) begin
        r_read_hit   <= w_set_rd_hit[w_rd_set];
        r_read_value <= w_set_rd_value[w_rd_set];
      end
      if (w_clear)    r_count <= '0;
      else if (w_inc) r_count <= r_count + CNT_W'(1);
      else if (w_dec) r_count <= r_count - CNT_W'(1);
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_code   = r_rsp_code;
  assign read_valid = r_read_valid;
  assign read_hit   = r_read_hit;
  assign read_value = r_read_value;
  assign count      = r_count;

endmodule

// File: tb/tb_assoc_hashmap.sv
// Directed bench: one evicting and one rejecting instance share stimulus and are checked against a set/way model.
module tb_assoc_hashmap;

  localparam int KW   = 8;
  localparam int VW   = 8;
  localparam int SETS = 4;
  localparam int WAYS = 2;
  localparam int CW   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cmd_valid;
  logic [1:0]    cmd_op;
  logic [KW-1:0] cmd_key;
  logic [VW-1:0] cmd_value;
  logic          read_request;
  logic [KW-1:0] read_key;

  logic [1:0]         rsp_valid_d;
  logic [1:0][1:0]    rsp_code_d;
  logic [1:0]         read_valid_d;
  logic [1:0]         read_hit_d;
  logic [1:0][VW-1:0] read_value_d;
  logic [1:0][CW-1:0] count_d;

  // Instance 0 evicts on a full set, instance 1 rejects.
  assoc_hashmap #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .SETS(SETS), .WAYS(WAYS), .OVERWRITE(1'b1)) dut_ow (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_key(cmd_key),
    .cmd_value(cmd_value), .rsp_valid(rsp_valid_d[0]), .rsp_code(rsp_code_d[0]),
    .read_request(read_request), .read_key(read_key), .read_valid(read_valid_d[0]),
    .read_hit(read_hit_d[0]), .read_value(read_value_d[0]), .count(count_d[0])
  );

  assoc_hashmap #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .SETS(SETS), .WAYS(WAYS), .OVERWRITE(1'b0)) dut_rj (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_key(cmd_key),
    .cmd_value(cmd_value), .rsp_valid(rsp_valid_d[1]), .rsp_code(rsp_code_d[1]),
    .read_request(read_request), .read_key(read_key), .read_valid(read_valid_d[1]),
    .read_hit(read_hit_d[1]), .read_value(read_value_d[1]), .count(count_d[1])
  );

  // ---------------- model + scoreboard ----------------
  logic          mv   [2][SETS][WAYS];
  logic [KW-1:0] mk   [2][SETS][WAYS];
  logic [VW-1:0] mval [2][SETS][WAYS];
  int            mvic [2][SETS];
  int            mcnt [2];

  logic          exp_rv;
  logic          exp_rdv [2];
  logic          exp_hit [2];
  logic [VW-1:0] exp_val [2];
  int            exp_cnt [2];
  logic [3:0]    exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < SETS; s++) begin
        mvic[d][s] = 0;
        for (int w = 0; w < WAYS; w++) mv[d][s][w] = 1'b0;
      end
      mcnt[d]    = 0;
      exp_rdv[d] = 1'b0;
      exp_hit[d] = 1'b0;
      exp_val[d] = '0;
      exp_cnt[d] = 0;
    end
    exp_rv = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic cv, input logic [1:0] op, input logic [KW-1:0] k,
                            input logic [VW-1:0] v, input logic rr, input logic [KW-1:0] rk);
    logic [1:0] code [2];
    exp_rv = cv && (op != 2'd3);
    for (int d = 0; d < 2; d++) begin
      code[d] = 2'd0;
      if (rr) begin
        int rs = int'(rk) % SETS;
        exp_rdv[d] = 1'b1;
        exp_hit[d] = 1'b0;
        exp_val[d] = '0;
        for (int w = 0; w < WAYS; w++)
          if (mv[d][rs][w] && mk[d][rs][w] == rk) begin
            exp_hit[d] = 1'b1;
            exp_val[d] = mval[d][rs][w];
          end
      end else begin
        exp_rdv[d] = 1'b0;
      end
      if (cv) begin
        int s  = int'(k) % SETS;
        int hw = -1;
        int fw = -1;
        for (int w = 0; w < WAYS; w++) begin
          if (mv[d][s][w] && mk[d][s][w] == k) hw = w;
          if (!mv[d][s][w] && fw < 0) fw = w;
        end
        case (op)
          2'd0: begin
            if (hw >= 0) begin
              mval[d][s][hw] = v;
              code[d] = 2'd1;
            end else if (fw >= 0) begin
              mv[d][s][fw] = 1'b1;
              mk[d][s][fw] = k;
              mval[d][s][fw] = v;
              mcnt[d]++;
              code[d] = 2'd0;
            end else if (d == 0) begin
              mk[d][s][mvic[d][s]] = k;
              mval[d][s][mvic[d][s]] = v;
              mvic[d][s] = (mvic[d][s] + 1) % WAYS;
              code[d] = 2'd2;
            end else begin
              code[d] = 2'd3;
            end
          end
          2'd1: begin
            if (hw >= 0) begin
              mv[d][s][hw] = 1'b0;
              mcnt[d]--;
              code[d] = 2'd0;
            end else begin
              code[d] = 2'd3;
            end
          end
          2'd2: begin
            for (int ss = 0; ss < SETS; ss++) begin
              mvic[d][ss] = 0;
              for (int w = 0; w < WAYS; w++) mv[d][ss][w] = 1'b0;
            end
            mcnt[d] = 0;
          end
          default: ;
        endcase
      end
      exp_cnt[d] = mcnt[d];
    end
    if (exp_rv) exp_q.push_back({code[1], code[0]});
  endtask

  task automatic compare();
    logic [3:0] c;
    c = 4'd0;
    if (exp_rv) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        c = exp_q.pop_front();
        chk("d0 rsp_code", 32'(rsp_code_d[0]), 32'(c[1:0]));
        chk("d1 rsp_code", 32'(rsp_code_d[1]), 32'(c[3:2]));
      end
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rsp_valid", d),  32'(rsp_valid_d[d]),  32'(exp_rv));
      chk($sformatf("d%0d read_valid", d), 32'(read_valid_d[d]), 32'(exp_rdv[d]));
      chk($sformatf("d%0d read_hit", d),   32'(read_hit_d[d]),   32'(exp_hit[d]));
      chk($sformatf("d%0d read_value", d), 32'(read_value_d[d]), 32'(exp_val[d]));
      chk($sformatf("d%0d count", d),      32'(count_d[d]),      32'(exp_cnt[d]));
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic cv, input logic [1:0] op, input logic [KW-1:0] k,
                     input logic [VW-1:0] v, input logic rr, input logic [KW-1:0] rk);
    @(negedge clk);
    cmd_valid    = cv;
    cmd_op       = op;
    cmd_key      = k;
    cmd_value    = v;
    read_request = rr;
    read_key     = rk;
    model_step(cv, op, k, v, rr, rk);
    @(posedge clk);
    #2;
    compare();
  endtask

  task automatic wr(input logic [KW-1:0] k, input logic [VW-1:0] v);
    cyc(1'b1, 2'd0, k, v, 1'b0, '0);
  endtask

  task automatic del(input logic [KW-1:0] k);
    cyc(1'b1, 2'd1, k, '0, 1'b0, '0);
  endtask

  task automatic rd(input logic [KW-1:0] k);
    cyc(1'b0, 2'd0, '0, '0, 1'b1, k);
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d rsp_valid", tag, d),  32'(rsp_valid_d[d]),  32'd0);
      chk($sformatf("%s d%0d rsp_code", tag, d),   32'(rsp_code_d[d]),   32'd0);
      chk($sformatf("%s d%0d read_valid", tag, d), 32'(read_valid_d[d]), 32'd0);
      chk($sformatf("%s d%0d read_hit", tag, d),   32'(read_hit_d[d]),   32'd0);
      chk($sformatf("%s d%0d read_value", tag, d), 32'(read_value_d[d]), 32'd0);
      chk($sformatf("%s d%0d count", tag, d),      32'(count_d[d]),      32'd0);
    end
  endtask

  // Keys 0/4/8/12 crowd set 0 and 3/7 land in set 3; set 2 is left alone.
  logic [KW-1:0] tbl_keys [6] = '{8'd0, 8'd4, 8'd8, 8'd3, 8'd7, 8'd12};

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_key = '0; cmd_value = '0;
    read_request = 1'b0; read_key = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    rd(8'd5);
    chk("lit rd5 valid", 32'(read_valid_d[0]), 32'd1);
    chk("lit rd5 hit",   32'(read_hit_d[0]),   32'd0);
    chk("lit rd5 count", 32'(count_d[0]),      32'd0);

    wr(8'd5, 8'h0A);
    chk("lit wr5 code",  32'(rsp_code_d[0]), 32'd0);
    chk("lit wr5 count", 32'(count_d[0]),    32'd1);
    rd(8'd5);
    chk("lit rd5 value", 32'(read_value_d[0]), 32'h0A);
    wr(8'd5, 8'h0B);
    chk("lit upd code",  32'(rsp_code_d[0]), 32'd1);
    chk("lit upd count", 32'(count_d[1]),    32'd1);
    rd(8'd5);
    chk("lit upd value", 32'(read_value_d[1]), 32'h0B);

    cyc(1'b1, 2'd2, '0, '0, 1'b0, '0);
    chk("lit clear count", 32'(count_d[0]), 32'd0);

    // Three keys into set 1 of a 2-way set.
    wr(8'd1, 8'h11);
    wr(8'd5, 8'h55);
    wr(8'd9, 8'h99);
    chk("lit ow third code", 32'(rsp_code_d[0]), 32'd2);
    chk("lit rj third code", 32'(rsp_code_d[1]), 32'd3);
    chk("lit ow count",      32'(count_d[0]),    32'd2);
    chk("lit rj count",      32'(count_d[1]),    32'd2);
    chk("lit model ow cnt",  32'(exp_cnt[0]),    32'd2);
    rd(8'd1);
    chk("lit ow rd1 hit", 32'(read_hit_d[0]), 32'd0);
    chk("lit rj rd1 hit", 32'(read_hit_d[1]), 32'd1);
    rd(8'd9);
    chk("lit ow rd9 val", 32'(read_value_d[0]), 32'h99);
    chk("lit rj rd9 hit", 32'(read_hit_d[1]),   32'd0);
    wr(8'd13, 8'hDD);
    chk("lit ow wr13 code", 32'(rsp_code_d[0]), 32'd2);
    rd(8'd5);
    chk("lit ow rd5 evicted", 32'(read_hit_d[0]), 32'd0);
    rd(8'd13);

    del(8'd5);
    chk("lit rj del code",  32'(rsp_code_d[1]), 32'd0);
    chk("lit rj del count", 32'(count_d[1]),    32'd1);
    chk("lit ow del miss",  32'(rsp_code_d[0]), 32'd3);
    del(8'd5);
    chk("lit rj del again", 32'(rsp_code_d[1]), 32'd3);
    wr(8'd17, 8'h77);
    chk("lit rj refill code",  32'(rsp_code_d[1]), 32'd0);
    chk("lit rj refill count", 32'(count_d[1]),    32'd2);
    chk("lit ow evict 9",      32'(rsp_code_d[0]), 32'd2);
    rd(8'd17);
    rd(8'd9);

    // Same-cycle write and lookup of one key.
    cyc(1'b1, 2'd0, 8'd6, 8'h33, 1'b1, 8'd6);
    chk("lit same-cycle miss", 32'(read_hit_d[0]), 32'd0);
    rd(8'd6);
    chk("lit next-cycle val", 32'(read_value_d[0]), 32'h33);
    cyc(1'b0, 2'd0, '0, '0, 1'b0, '0);

    for (int i = 0; i < 6; i++) begin
      wr(tbl_keys[i], tbl_keys[i] ^ 8'h5A);
      rd(tbl_keys[(i + 3) % 6]);
    end
    wr(8'd3, 8'hC3);
    del(8'd12);
    for (int i = 0; i < 6; i++) rd(tbl_keys[i]);

    cyc(1'b1, 2'd3, 8'd0, 8'hFF, 1'b0, '0);
    chk("lit reserved no rsp", 32'(rsp_valid_d[0]), 32'd0);

    rd(8'd6);
    chk("lit pre-reset hit", 32'(read_hit_d[1]), 32'd1);
    // Asynchronous reset with a command in flight.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_key = 8'h22; cmd_value = 8'h44;
    read_request = 1'b1; read_key = 8'd6;
    #2 rst_n = 1'b0;
    #1 check_zero("async");
    model_reset();
    @(posedge clk);
    #2 compare();
    @(negedge clk);
    rst_n = 1'b1; cmd_valid = 1'b0; read_request = 1'b0;
    rd(8'd6);
    chk("lit post-reset miss", 32'(read_hit_d[0]), 32'd0);
    rd(8'h22);

    for (int k = 1; k <= 4; k++) wr(KW'(k), VW'(k * 16));
    chk("lit refill count", 32'(count_d[0]), 32'd4);
    cyc(1'b1, 2'd2, '0, '0, 1'b1, 8'd2);
    chk("lit clear rd sees old", 32'(read_hit_d[0]), 32'd1);
    chk("lit clear count 0",     32'(count_d[1]),    32'd0);
    for (int k = 1; k <= 4; k++) rd(KW'(k));
    cyc(1'b0, 2'd0, '0, '0, 1'b0, '0);

    chk("exp_q drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/assoc_hashmap.md
# assoc_hashmap

Set-associative key/value cache: SETS sets of WAYS entries, key hashed to a set by `key % SETS`. Supports insert/update, delete and clear through a command port with a registered status response, plus an independent registered lookup port. Replacement in a full set is round-robin eviction or rejection, selected by parameter. Keeps a live occupancy count. Drop-in successor to the direct-mapped hashmap for the deduplication and lookup stages of the solution datapaths.

## Interface
- KEY_WIDTH, 8, key bits
- VALUE_WIDTH, 8, value bits
- SETS, 4, number of sets, ≥1 (any integer)
- WAYS, 2, entries per set, ≥1
- OVERWRITE, 1, 1 = evict on full-set insert, 0 = reject
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command strobe; no backpressure, one command per cycle
- cmd_op  in  2  0 WRITE, 1 DELETE, 2 CLEAR, 3 reserved (treated as no-op, no response)
- cmd_key  in  KEY_WIDTH  command key
- cmd_value  in  VALUE_WIDTH  write value
- rsp_valid  out  1  one-cycle pulse, response to the previous cycle's command
- rsp_code  out  2  0 NEW, 1 UPDATED, 2 EVICTED, 3 FAIL
- read_request  in  1  lookup strobe
- read_key  in  KEY_WIDTH  lookup key
- read_valid  out  1  one-cycle pulse, lookup result
- read_hit  out  1  key present
- read_value  out  VALUE_WIDTH  stored value, 0 on miss
- count  out  $clog2(SETS*WAYS+1)  number of valid entries

## Operation
- Set index = key % SETS. A hit is a valid way in that set whose stored key equals the key; at most one way per set can hit.
- WRITE, hit: overwrite that way's value; code UPDATED; count unchanged.
- WRITE, miss, free way present: fill the lowest-index free way; code NEW; count +1.
- WRITE, miss, set full, OVERWRITE=1: replace the way at the set's victim pointer; code EVICTED; count unchanged; victim pointer advances, wrapping WAYS-1→0.
- WRITE, miss, set full, OVERWRITE=0: no state change; code FAIL.
- DELETE, hit: clear that way's valid bit; code NEW (0, meaning OK); count −1. DELETE, miss: code FAIL.
- CLEAR: all valid bits and victim pointers reset; count 0; code NEW.
- The victim pointer changes only on eviction. Deletes and fills do not move it.
- Lookup: read_hit and read_value come from the state before any command accepted on the same edge.

## Timing
- Command sampled at edge N; state update and rsp_valid/rsp_code visible after edge N. Latency is 1 cycle, throughput 1 per cycle. Back-to-back commands to the same key see the previous command's effect.
- Lookup sampled at edge N; read_valid/read_hit/read_value visible after edge N. A same-cycle WRITE of the looked-up key is not reflected; a lookup in the following cycle is.
- With read_request low, read_valid is 0 and read_hit/read_value hold their last values.
- Reset (rst_n low, asynchronous, any time including mid-command): rsp_valid 0, rsp_code 0, read_valid 0, read_hit 0, read_value 0, count 0, all valid bits 0, victim pointers 0. Key and value storage is not reset. The command in flight at reset is lost; no response is issued.
- count never exceeds SETS*WAYS and never underflows.

## Structure
- Shared package `hashmap_pkg`: op encodings (OP_WRITE, OP_DELETE, OP_CLEAR) and response encodings (RSP_NEW, RSP_UPDATED, RSP_EVICTED, RSP_FAIL).
- Sub-module `hashmap_set`, instantiated SETS times. It holds WAYS key/value/valid entries and the victim pointer, and exposes:
  - combinational hit / hit-way / free-way / full for the command key and for the read key;
  - a write/delete/clear interface.
- The top level does set selection, the response and read registers, and the count.

## Test plan
Bench configuration: SETS=4, WAYS=2, KEY_WIDTH=8.
- Reset, then lookup key 5 → read_valid 1, read_hit 0, read_value 0, count 0.
- WRITE (5,0x0A) → rsp NEW, count 1. Lookup 5 next cycle → hit, 0x0A. WRITE (5,0x0B) → UPDATED, count 1, lookup returns 0x0B.
- OVERWRITE=1: WRITE keys 1, 5, 9 (all set 1) → NEW, NEW, EVICTED; count 2. Lookup 1 → miss, 9 → hit. A further WRITE of 13 evicts key 5 (way 1).
- OVERWRITE=0, same sequence → third response FAIL, count 2, lookup 9 → miss.
- DELETE 5 → code 0, count −1. DELETE 5 again → FAIL. The next WRITE to set 1 fills the freed way with code NEW.
- Same-cycle WRITE (6,0x33) + lookup 6 → miss; lookup 6 next cycle → hit 0x33. rst_n pulled low mid-stream → outputs zero immediately, count 0. CLEAR after refill → count 0, all lookups miss.
